multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: IF/ID/EX/MEM/HALT sequencing, ID-stage decode, retired-instruction count.
// Optional MEM_WAIT_EN: lw/sw hold MEM until mem_ready; otherwise MEM is always one cycle.
module multicycle_ctrl #(
  parameter int unsigned OPW      = 4,
  parameter int unsigned ALUW     = 3,
  parameter int unsigned CNTW     = 16,
  parameter int unsigned SKIP_MEM = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  output logic [1:0]      pc_ctrl,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            alu_src,
  output logic            branch,
  output logic            jump,
  output logic            mem_write,
  output logic            mem_read,
  output logic            mem_to_reg,
  output logic [ALUW-1:0] alu_sel,
  output logic [2:0]      state,
  output logic            illegal,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StHalt = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ClsNone, ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsJump
  } class_e;

  typedef struct packed {
    logic            reg_dst;
    logic            alu_src;
    logic [ALUW-1:0] alu_sel;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
    logic            jump;
  } ctrl_t;

  localparam logic [ALUW-1:0] AluSub = ALUW'(1);
  localparam logic [ALUW-1:0] AluSlt = ALUW'(2);
  localparam logic [ALUW-1:0] AluAnd = ALUW'(4);

  state_e          state_q, state_d;
  class_e          class_q, class_d, dec_class;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [OPW-1:0]  op_hi;
  logic            dec_legal, dec_halt;
  ctrl_t           dec, ctrl;

  assign op_hi = opcode >> 4;

  always_comb begin
    dec       = '0;
    dec_class = ClsNone;
    dec_legal = 1'b0;
    dec_halt  = 1'b0;
    if (op_hi == '0) begin
      dec_legal = 1'b1;
      case (opcode[3:0])
        4'd0: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec_class = ClsAlu; end
        4'd1: begin
          dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_sel = AluSub; dec_class = ClsAlu;
        end
        4'd2: begin
          dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_sel = AluSlt; dec_class = ClsAlu;
        end
        4'd3: begin
          dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
          dec.mem_to_reg = 1'b1; dec_class = ClsLoad;
        end
        4'd4: begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec_class = ClsStore; end
        4'd5: begin dec.alu_sel = AluSub; dec.branch = 1'b1; dec_class = ClsBranch; end
        4'd6: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec_class = ClsAlu; end
        4'd7: begin
          dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_sel = AluAnd; dec_class = ClsAlu;
        end
        4'd8, 4'd9, 4'd10: begin dec.jump = 1'b1; dec_class = ClsJump; end
        4'd15: dec_halt = 1'b1;
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    pc_ctrl   = 2'd0;
    ctrl      = '0;
    unique case (state_q)
      StId: begin
        ctrl = dec;
        if (dec_halt || !dec_legal) begin
          state_d   = StHalt;
          class_d   = ClsNone;
          illegal_d = illegal_q | ~dec_legal;
        end else begin
          state_d = StEx;
          class_d = dec_class;
          count_d = count_q + CNTW'(1);
        end
      end
      StEx: state_d = (SKIP_MEM != 0 && class_q == ClsAlu) ? StIf : StMem;
      StMem: begin
`ifdef MEM_WAIT_EN
        if ((class_q == ClsLoad || class_q == ClsStore) && !mem_ready) begin
          state_d = StMem;
        end else begin
          pc_ctrl = 2'd2;
          state_d = StIf;
        end
`else
        pc_ctrl = 2'd2;
        state_d = StIf;
`endif
      end
      StHalt: state_d = StHalt;
      // IF, plus the unreachable encodings 5-7 which behave as IF
      default: begin
        if (run) begin
          pc_ctrl = 2'd1;
          state_d = StId;
        end else begin
          state_d = StIf;
        end
      end
    endcase
    if (reset) begin
      pc_ctrl = 2'd0;
      ctrl    = '0;
    end
  end

`ifndef MEM_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIf;
      class_q   <= ClsNone;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign reg_dst     = ctrl.reg_dst;
  assign alu_src     = ctrl.alu_src;
  assign alu_sel     = ctrl.alu_sel;
  assign reg_write   = ctrl.reg_write;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign branch      = ctrl.branch;
  assign jump        = ctrl.jump;
  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from the opcode table.
// A second instance with a 2-bit counter shares the stimulus to exercise counter wrap.
module tb_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset, run, mem_ready;
  logic [3:0] opcode;

  logic [1:0]  pc_ctrl, b_pc_ctrl;
  logic        reg_write, reg_dst, alu_src, branch, jump, mem_write, mem_read, mem_to_reg;
  logic        b_reg_write, b_reg_dst, b_alu_src, b_branch, b_jump;
  logic        b_mem_write, b_mem_read, b_mem_to_reg;
  logic [2:0]  alu_sel, b_alu_sel, state, b_state;
  logic        illegal, b_illegal;
  logic [15:0] instr_count;
  logic [1:0]  b_instr_count;

  multicycle_ctrl dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_ctrl(pc_ctrl), .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .branch(branch), .jump(jump), .mem_write(mem_write), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .alu_sel(alu_sel), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  multicycle_ctrl #(.CNTW(2)) dut_w2 (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_ctrl(b_pc_ctrl), .reg_write(b_reg_write), .reg_dst(b_reg_dst), .alu_src(b_alu_src),
    .branch(b_branch), .jump(b_jump), .mem_write(b_mem_write), .mem_read(b_mem_read),
    .mem_to_reg(b_mem_to_reg), .alu_sel(b_alu_sel), .state(b_state), .illegal(b_illegal),
    .instr_count(b_instr_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int unsigned exp_count;
  bit exp_illegal;

  wire [10:0] obs_ctrl = {reg_dst, alu_src, alu_sel, reg_write, mem_read, mem_write,
                          mem_to_reg, branch, jump};

  // {reg_dst, alu_src, alu_sel[2:0], reg_write, mem_read, mem_write, mem_to_reg, branch, jump}
  function automatic logic [10:0] ref_ctrl(int op);
    case (op)
      0:        return 11'b1_0_000_1_0_0_0_0_0;
      1:        return 11'b1_0_001_1_0_0_0_0_0;
      2:        return 11'b1_0_010_1_0_0_0_0_0;
      3:        return 11'b0_1_000_1_1_0_1_0_0;
      4:        return 11'b0_1_000_0_0_1_0_0_0;
      5:        return 11'b0_0_001_0_0_0_0_1_0;
      6:        return 11'b0_1_000_1_0_0_0_0_0;
      7:        return 11'b0_1_100_1_0_0_0_0_0;
      8, 9, 10: return 11'b0_0_000_0_0_0_0_0_1;
      default:  return 11'b0;
    endcase
  endfunction

  function automatic bit is_alu(int op);
    return op == 0 || op == 1 || op == 2 || op == 6 || op == 7;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Inputs already applied; settle, compare this cycle's outputs, then advance one clock.
  task automatic cyc(string tag, int st, int pc, logic [10:0] ctl);
    #2;
    check({tag, "/state"}, 32'(state), 32'(st));
    check({tag, "/pc_ctrl"}, 32'(pc_ctrl), 32'(pc));
    check({tag, "/ctrl"}, 32'(obs_ctrl), 32'(ctl));
    tick();
  endtask

  task automatic check_counts(string tag);
    #2;
    check({tag, "/count"}, 32'(instr_count), exp_count & 32'hFFFF);
    check({tag, "/count_w2"}, 32'(b_instr_count), exp_count % 4);
    check({tag, "/illegal"}, 32'(illegal), 32'(exp_illegal));
  endtask

  task automatic do_reset(string tag);
    reset  = 1'b1;
    run    = 1'($urandom);
    opcode = 4'($urandom);
    #2;
    check({tag, "/rst_pc"}, 32'(pc_ctrl), 0);
    check({tag, "/rst_ctrl"}, 32'(obs_ctrl), 0);
    tick();
    exp_count   = 0;
    exp_illegal = 1'b0;
    check({tag, "/rst_state"}, 32'(state), 0);
    check_counts(tag);
    reset = 1'b0;
  endtask

  // One instruction: optional idle cycles in IF, then IF/ID/(EX/MEM or HALT).
  task automatic do_instr(int op, int idle);
    bit halted;
    for (int i = 0; i < idle; i++) begin
      run       = 1'b0;
      opcode    = 4'($urandom);
      mem_ready = 1'($urandom);
      cyc("idle", 0, 0, 11'b0);
    end
    run    = 1'b1;
    opcode = 4'(op);
    cyc("if", 0, 1, 11'b0);
    run = 1'($urandom);
    cyc("id", 1, 0, ref_ctrl(op));
    halted = (op >= 11);
    if (op >= 11 && op != 15) exp_illegal = 1'b1;
    if (!halted) exp_count++;
    opcode = 4'($urandom);
    if (halted) begin
      cyc("halt", 4, 0, 11'b0);
      check_counts("halt");
      return;
    end
    run = 1'($urandom);
    cyc("ex", 2, 0, 11'b0);
    if (!is_alu(op)) begin
`ifdef MEM_WAIT_EN
      if (op == 3 || op == 4) begin
        int waits = $urandom_range(0, 3);
        for (int i = 0; i < waits; i++) begin
          mem_ready = 1'b0;
          cyc("memwait", 3, 0, 11'b0);
        end
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom);
      end
`else
      mem_ready = 1'($urandom);
`endif
      cyc("mem", 3, 2, 11'b0);
    end
    check_counts("retire");
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    mem_ready = 1'b0;
    opcode    = 4'd0;
    exp_count = 0;
    exp_illegal = 1'b0;
    tick();
    do_reset("init");

    do_instr(0, 0);
    do_instr(5, 0);
    do_instr(3, 0);
    do_instr(4, 1);
    do_instr(0, 5);
    for (int i = 0; i < 4; i++) do_instr(0, 0);

    for (int i = 0; i < 60; i++) do_instr($urandom_range(0, 10), $urandom_range(0, 2));

    // Reset while in ID: controls must be suppressed.
    run    = 1'b1;
    opcode = 4'd0;
    cyc("pre_id", 0, 1, 11'b0);
    opcode = 4'd0;
    do_reset("rst_in_id");

    // Reset while in MEM (waiting if the wait feature is built in).
    do_instr(1, 0);
    run    = 1'b1;
    opcode = 4'd3;
    cyc("if_lw", 0, 1, 11'b0);
    cyc("id_lw", 1, 0, ref_ctrl(3));
    mem_ready = 1'b0;
    cyc("ex_lw", 2, 0, 11'b0);
    #2;
    check("in_mem/state", 32'(state), 3);
    do_reset("rst_in_mem");

    // Illegal opcode halts; run has no effect until reset.
    do_instr(2, 0);
    do_instr(12, 0);
    for (int i = 0; i < 4; i++) begin
      run    = ~run;
      opcode = 4'($urandom);
      cyc("halt_hold", 4, 0, 11'b0);
    end
    check_counts("halt_hold");
    do_reset("rst_in_halt");

    do_instr(15, 1);
    run = 1'b1;
    cyc("halt15_hold", 4, 0, 11'b0);
    check_counts("halt15");
    do_reset("rst_after_15");

    do_instr($urandom_range(11, 14), 0);
    do_reset("rst_after_illegal");
    do_instr(7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
